// File: rtl/mux_4to1_pkg.sv
// Shared types and constants for the 4:1 selector and its register stage.
package mux_4to1_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_I0 = 2'b00;
    localparam sel_t SEL_I1 = 2'b01;
    localparam sel_t SEL_I2 = 2'b10;
    localparam sel_t SEL_I3 = 2'b11;

    localparam int DATA_W_DEF = 1;

endpackage

// File: rtl/mux_4to1_core.sv
// Purely combinational 4:1 lane selector; lane k lives at data_i[k*DATA_W +: DATA_W].
module mux_4to1_core
    import mux_4to1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [4*DATA_W-1:0] data_i,
    input  sel_t                sel_i,
    output logic [DATA_W-1:0]   out_o
);

    always_comb begin
        out_o = '0;
        case (sel_i)
            SEL_I0:  out_o = data_i[0*DATA_W +: DATA_W];
            SEL_I1:  out_o = data_i[1*DATA_W +: DATA_W];
            SEL_I2:  out_o = data_i[2*DATA_W +: DATA_W];
            SEL_I3:  out_o = data_i[3*DATA_W +: DATA_W];
            default: out_o = '0;
        endcase
    end

endmodule

// File: rtl/mux_4to1.sv
// 4:1 selector with a registered copy of the output and a select-change flag.
// Define MUX4TO1_PARITY_EN to add parity_q, the registered even parity of out.
module mux_4to1
    import mux_4to1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DATA_W-1:0] i,
    input  sel_t                sel,
    output logic [DATA_W-1:0]   out,
    output logic [DATA_W-1:0]   out_q,
    output logic                sel_chg
`ifdef MUX4TO1_PARITY_EN
    ,
    output logic                parity_q
`endif
);

    logic [DATA_W-1:0] out_d;
    sel_t              sel_prev_q;
    sel_t              sel_prev_d;
    logic              sel_chg_q;
    logic              sel_chg_d;

    mux_4to1_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .data_i (i),
        .sel_i  (sel),
        .out_o  (out)
    );

    assign out_d      = out;
    assign sel_prev_d = sel;
    // sel_prev resets to lane 0, so leaving reset on any other lane flags a change
    assign sel_chg_d  = (sel != sel_prev_q);
    assign sel_chg    = sel_chg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            sel_prev_q <= SEL_I0;
            sel_chg_q  <= 1'b0;
        end else begin
            out_q      <= out_d;
            sel_prev_q <= sel_prev_d;
            sel_chg_q  <= sel_chg_d;
        end
    end

`ifdef MUX4TO1_PARITY_EN
    logic parity_d;

    assign parity_d = ^out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1: combinational lane checks plus a scoreboard for the register stage.
module tb_mux_4to1;

`ifdef MUX4TO1_PARITY_EN
    localparam int DW = 4;
`else
    localparam int DW = 1;
`endif

    typedef struct {
        logic [DW-1:0] oq;
        logic          chg;
        logic          par;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [4*DW-1:0] i;
    logic [1:0]      sel;
    logic [DW-1:0]   out;
    logic [DW-1:0]   out_q;
    logic            sel_chg;
`ifdef MUX4TO1_PARITY_EN
    logic            parity_q;
`endif

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];
    logic [1:0]    model_prev;
    logic [DW-1:0] last_oq;

    localparam logic [DW-1:0] ZERO = '0;
    localparam logic [DW-1:0] ONES = '1;

    mux_4to1 #(.DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .sel     (sel),
        .out     (out),
        .out_q   (out_q),
        .sel_chg (sel_chg)
`ifdef MUX4TO1_PARITY_EN
        ,
        .parity_q(parity_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] lane_of(input logic [4*DW-1:0] iv, input logic [1:0] s);
        return iv[int'(s)*DW +: DW];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive between edges, check the combinational path, then score the registered outputs.
    task automatic step(input string tag, input logic [4*DW-1:0] iv, input logic [1:0] s);
        exp_t e;
        exp_t got;
        @(negedge clk);
        i   = iv;
        sel = s;
        e.oq  = lane_of(iv, s);
        e.chg = (s != model_prev);
        e.par = ^lane_of(iv, s);
        model_prev = s;
        sb.push_back(e);
        #1;
        check({tag, "_out"}, 32'(out), 32'(e.oq));
        check({tag, "_lag"}, 32'(out_q), 32'(last_oq));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL %s_sb: observed empty queue required one entry", tag);
        end else begin
            got = sb.pop_front();
            check({tag, "_out_q"}, 32'(out_q), 32'(got.oq));
            check({tag, "_sel_chg"}, 32'(sel_chg), 32'(got.chg));
`ifdef MUX4TO1_PARITY_EN
            check({tag, "_parity_q"}, 32'(parity_q), 32'(got.par));
`endif
            last_oq = got.oq;
        end
    endtask

    initial begin
        logic [4*DW-1:0] p1010;
        logic [4*DW-1:0] p0101;
        logic [4*DW-1:0] rv;
        logic [1:0]      rs;

        p1010 = {ONES, ZERO, ONES, ZERO};
        p0101 = {ZERO, ONES, ZERO, ONES};
        model_prev = 2'b00;
        last_oq    = '0;

        rst = 1'b1;
        i   = '0;
        sel = 2'b00;
        #2;
        check("reset_out_q", 32'(out_q), 32'(ZERO));
        check("reset_sel_chg", 32'(sel_chg), 0);
`ifdef MUX4TO1_PARITY_EN
        check("reset_parity_q", 32'(parity_q), 0);
`endif

        // Combinational path while reset is held.
        i = p1010;
        sel = 2'b00; #2; check("t1_sel00", 32'(out), 32'(ZERO));
        sel = 2'b01; #2; check("t1_sel01", 32'(out), 32'(ONES));
        sel = 2'b10; #2; check("t1_sel10", 32'(out), 32'(ZERO));
        sel = 2'b11; #2; check("t1_sel11", 32'(out), 32'(ONES));
        i = p0101;
        sel = 2'b00; #2; check("t2_sel00", 32'(out), 32'(ONES));
        sel = 2'b01; #2; check("t2_sel01", 32'(out), 32'(ZERO));
        sel = 2'b10; #2; check("t2_sel10", 32'(out), 32'(ONES));
        sel = 2'b11; #2; check("t2_sel11", 32'(out), 32'(ZERO));
        @(posedge clk);
        #1;
        check("t2_out_q_in_reset", 32'(out_q), 32'(ZERO));
        check("t2_sel_chg_in_reset", 32'(sel_chg), 0);

        // First edges after reset release with sel=01.
        rst = 1'b0;
        step("t3_first", p1010, 2'b01);
        step("t3_hold", p1010, 2'b01);

        // Walk sel 00..11 on successive edges, then hold.
        step("t4_s0", p1010, 2'b00);
        step("t4_s1", p1010, 2'b01);
        step("t4_s2", p1010, 2'b10);
        step("t4_s3", p1010, 2'b11);
        step("t4_hold", p1010, 2'b11);

        // Asynchronous reset between edges while out_q = 1.
        check("t5_pre_out_q", 32'(out_q), 32'(ONES));
        #2;
        rst = 1'b1;
        #1;
        check("t5_out_q_cleared", 32'(out_q), 32'(ZERO));
        check("t5_sel_chg_cleared", 32'(sel_chg), 0);
        check("t5_out_tracks", 32'(out), 32'(ONES));
`ifdef MUX4TO1_PARITY_EN
        check("t5_parity_cleared", 32'(parity_q), 0);
`endif
        @(posedge clk);
        #1;
        check("t5_out_q_held", 32'(out_q), 32'(ZERO));
        rst        = 1'b0;
        model_prev = 2'b00;
        last_oq    = '0;

        // Data and select changing together.
        for (int k = 0; k < 12; k++) begin
            rv = (4*DW)'($urandom);
            rs = 2'($urandom_range(0, 3));
            step("rand", rv, rs);
        end

`ifdef MUX4TO1_PARITY_EN
        step("t6", 16'hF731, 2'b01);
        check("t6_out_const", 32'(out_q), 32'h3);
        check("t6_parity_const", 32'(parity_q), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
